// File: rtl/spi_byte_ctrl.sv
// SPI mode-0 single-byte master sequencer driving an external universal shift register.
// Define SPI_LSB_FIRST_EN to shift right and put the LSB on the wire first.
module spi_byte_ctrl #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_sclk,
    output logic       o_cs_n,
    output logic       o_mosi,
    input  logic       i_miso,
    output logic       o_sr_s0,
    output logic       o_sr_s1,
    output logic       o_sr_oe0,
    output logic       o_sr_oe1,
    output logic [7:0] o_sr_parallel,
    output logic       o_sr_serial,
    input  logic [7:0] i_sr_parallel
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOW,
        S_HIGH,
        S_TRAIL,
        S_DONE
    } state_e;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    // Mode selects packed as {s0, s1}
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b11;
`ifdef SPI_LSB_FIRST_EN
    localparam logic [1:0] SEL_SHIFT = 2'b10;
    localparam int unsigned MOSI_BIT = 0;
`else
    localparam logic [1:0] SEL_SHIFT = 2'b01;
    localparam int unsigned MOSI_BIT = 7;
`endif

    state_e     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic       miso_q, miso_d;
    logic       sclk_q, sclk_d;
    logic       cs_n_q, cs_n_d;
    logic       ready_q, ready_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [7:0] tx_q, tx_d;
    logic       div_end;
    logic [1:0] sr_sel;

    assign div_end = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        miso_d    = miso_q;
        tx_d      = tx_q;
        rx_data_d = rx_data_q;
        sr_sel    = SEL_HOLD;

        unique case (state_q)
            S_IDLE: begin
                if (i_tx_valid && ready_q) begin
                    tx_d    = i_tx_data;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sr_sel  = SEL_LOAD;
                state_d = S_LOW;
            end
            S_LOW: begin
                if (div_end) begin
                    miso_d  = i_miso;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (div_end) begin
                    // register shifts on the same edge that drops sclk
                    sr_sel  = SEL_SHIFT;
                    bit_d   = bit_q + 3'd1;
                    state_d = (bit_q == 3'd7) ? S_TRAIL : S_LOW;
                end
            end
            S_TRAIL: begin
                if (div_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bit_d   = 3'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q || state_q == S_IDLE) begin
            div_d = 8'd0;
        end else begin
            div_d = div_q + 8'd1;
        end

        if (state_d == S_DONE && state_q != S_DONE) begin
            rx_data_d = i_sr_parallel;
        end

        sclk_d     = (state_d == S_HIGH);
        cs_n_d     = (state_d == S_IDLE) || (state_d == S_DONE);
        ready_d    = (state_d == S_IDLE);
        rx_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= 8'd0;
            bit_q      <= 3'd0;
            miso_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            ready_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'd0;
            tx_q       <= 8'd0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            miso_q     <= miso_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            ready_q    <= ready_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            tx_q       <= tx_d;
        end
    end

    assign o_tx_ready    = ready_q;
    assign o_rx_data     = rx_data_q;
    assign o_rx_valid    = rx_valid_q;
    assign o_sclk        = sclk_q;
    assign o_cs_n        = cs_n_q;
    assign o_mosi        = i_sr_parallel[MOSI_BIT];
    assign o_sr_s0       = sr_sel[1];
    assign o_sr_s1       = sr_sel[0];
    assign o_sr_oe0      = 1'b0;
    assign o_sr_oe1      = cs_n_q;
    assign o_sr_parallel = tx_q;
    assign o_sr_serial   = miso_q;

endmodule

// File: tb/tb_spi_byte_ctrl.sv
// Bench for spi_byte_ctrl: shift-register and slave models around two
// instances (CLK_DIV=2 with a slave, CLK_DIV=1 in MOSI->MISO loopback).
module tb_spi_byte_ctrl;

    localparam int CD = 2;
`ifdef SPI_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif
    // legal shift code as {s1, s0}
    localparam logic [1:0] SHIFT_CODE = LSB ? 2'b01 : 2'b10;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       o_tx_ready, o_rx_valid, o_sclk, o_cs_n, o_mosi;
    logic [7:0] o_rx_data, o_sr_parallel;
    logic       o_sr_s0, o_sr_s1, o_sr_oe0, o_sr_oe1, o_sr_serial;
    logic       miso;
    logic [7:0] sr;

    spi_byte_ctrl #(.CLK_DIV(CD)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_tx_data(tx_data), .i_tx_valid(tx_valid),
        .o_tx_ready(o_tx_ready),
        .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
        .o_sclk(o_sclk), .o_cs_n(o_cs_n), .o_mosi(o_mosi),
        .i_miso(miso),
        .o_sr_s0(o_sr_s0), .o_sr_s1(o_sr_s1),
        .o_sr_oe0(o_sr_oe0), .o_sr_oe1(o_sr_oe1),
        .o_sr_parallel(o_sr_parallel),
        .o_sr_serial(o_sr_serial),
        .i_sr_parallel(sr)
    );

    logic [7:0] tx_data1 = 8'd0;
    logic       tx_valid1 = 1'b0;
    logic       rdy1, rxv1, sclk1, csn1, mosi1;
    logic [7:0] rxd1, par1;
    logic       s0_1, s1_1, oe0_1, oe1_1, ser1;
    logic [7:0] sr1;

    spi_byte_ctrl #(.CLK_DIV(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_tx_data(tx_data1), .i_tx_valid(tx_valid1),
        .o_tx_ready(rdy1),
        .o_rx_data(rxd1), .o_rx_valid(rxv1),
        .o_sclk(sclk1), .o_cs_n(csn1), .o_mosi(mosi1),
        .i_miso(mosi1),
        .o_sr_s0(s0_1), .o_sr_s1(s1_1),
        .o_sr_oe0(oe0_1), .o_sr_oe1(oe1_1),
        .o_sr_parallel(par1),
        .o_sr_serial(ser1),
        .i_sr_parallel(sr1)
    );

    // 74194-style universal register models
    always_ff @(posedge clk) begin
        case ({o_sr_s1, o_sr_s0})
            2'b11:   sr <= o_sr_parallel;
            2'b10:   sr <= {sr[6:0], o_sr_serial};
            2'b01:   sr <= {o_sr_serial, sr[7:1]};
            default: sr <= sr;
        endcase
        case ({s1_1, s0_1})
            2'b11:   sr1 <= par1;
            2'b10:   sr1 <= {sr1[6:0], ser1};
            2'b01:   sr1 <= {ser1, sr1[7:1]};
            default: sr1 <= sr1;
        endcase
    end

    // Slave: presents bit k of its byte before the k-th rise
    logic [7:0] slave_byte = 8'd0;
    logic [3:0] rc = 4'd0;
    logic [7:0] mosi_cap = 8'd0;
    logic       sclk_p = 1'b0;
    int         hi = 0;
    logic       width_bad = 1'b0;
    logic       mode_bad = 1'b0;

    assign miso = (rc < 4'd8) ?
        slave_byte[LSB ? rc[2:0] : ~rc[2:0]] : 1'b0;

    always_ff @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            hi     <= 0;
            sclk_p <= 1'b0;
        end else begin
            sclk_p <= o_sclk;
            if (o_sclk) begin
                hi <= hi + 1;
            end else begin
                if (sclk_p && hi != CD) width_bad <= 1'b1;
                hi <= 0;
            end
        end
        if (o_cs_n) begin
            rc <= 4'd0;
        end else if (o_sclk && !sclk_p) begin
            rc       <= rc + 4'd1;
            mosi_cap <= {mosi_cap[6:0], o_mosi};
        end
        if ({o_sr_s1, o_sr_s0} != 2'b00 &&
            {o_sr_s1, o_sr_s0} != 2'b11 &&
            {o_sr_s1, o_sr_s0} != SHIFT_CODE) begin
            mode_bad <= 1'b1;
        end
    end

    // Byte as seen on the wire, first bit in the MSB
    function automatic logic [7:0] wire_order(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7 - i];
        return LSB ? r : b;
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] tx, input logic [7:0] nxt,
                        input bit hold, output int acc);
        int w;
        w = 0;
        while (!o_tx_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("ready", o_tx_ready, 1);
        tx_data  = tx;
        tx_valid = 1'b1;
        @(negedge clk);
        acc = cyc;
        chk("load_csn", o_cs_n, 0);
        chk("load_mode", {o_sr_s1, o_sr_s0}, 2'b11);
        chk("load_rdy", o_tx_ready, 0);
        chk("load_oe1", o_sr_oe1, 0);
        tx_data = nxt;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic recv(input int acc, input logic [7:0] tx,
                        input logic [7:0] slv);
        int w;
        w = 0;
        while (!o_rx_valid && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("rx_latency", cyc - acc, 1 + 17 * CD);
        chk("rx_data", o_rx_data, slv);
        chk("mosi_bits", mosi_cap, wire_order(tx));
        chk("sclk_pulses", rc, 8);
        chk("sclk_width", width_bad, 0);
        chk("sr_mode", mode_bad, 0);
        chk("done_csn", o_cs_n, 1);
        @(negedge clk);
        chk("rxv_one_cycle", o_rx_valid, 0);
        chk("idle_ready", o_tx_ready, 1);
        chk("idle_csn", o_cs_n, 1);
        chk("rx_hold", o_rx_data, slv);
    endtask

    initial begin
        int acc, acc2, w;
        logic [7:0] tx, slv;
        logic seen;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_csn", o_cs_n, 1);
        chk("rst_sclk", o_sclk, 0);
        chk("rst_ready", o_tx_ready, 0);
        chk("rst_rxv", o_rx_valid, 0);
        chk("rst_rxd", o_rx_data, 8'h00);
        chk("rst_par", o_sr_parallel, 8'h00);
        chk("rst_ser", o_sr_serial, 0);
        chk("rst_mode", {o_sr_s1, o_sr_s0}, 2'b00);
        chk("rst_oe", {o_sr_oe1, o_sr_oe0}, 2'b10);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", o_tx_ready, 1);

        slave_byte = LSB ? 8'h80 : 8'h3C;
        tx = LSB ? 8'h01 : 8'hA5;
        send(tx, 8'h00, 1'b0, acc);
        recv(acc, tx, slave_byte);

        slave_byte = 8'h11 ^ 8'hF0;
        send(8'h11, 8'h22, 1'b1, acc);
        recv(acc, 8'h11, slave_byte);
        slave_byte = 8'h4B;
        @(negedge clk);
        acc2 = cyc;
        chk("b2b_load_csn", o_cs_n, 0);
        chk("b2b_load_mode", {o_sr_s1, o_sr_s0}, 2'b11);
        chk("b2b_gap", acc2 - acc, 1 + 17 * CD + 2);
        tx_valid = 1'b0;
        recv(acc2, 8'h22, slave_byte);

        slave_byte = 8'hE7;
        send(8'h00, 8'hFF, 1'b0, acc);
        recv(acc, 8'h00, slave_byte);

        for (int i = 0; i < 6; i++) begin
            tx  = 8'($urandom);
            slv = 8'($urandom);
            slave_byte = slv;
            send(tx, 8'($urandom), 1'b0, acc);
            recv(acc, tx, slv);
        end

        slave_byte = 8'h69;
        send(8'h96, 8'h00, 1'b0, acc);
        w = 0;
        while (rc < 4'd3 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("rst_reach_bit3", rc, 3);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_csn", o_cs_n, 1);
        chk("arst_sclk", o_sclk, 0);
        chk("arst_mode", {o_sr_s1, o_sr_s0}, 2'b00);
        chk("arst_oe1", o_sr_oe1, 1);
        chk("arst_ready", o_tx_ready, 0);
        seen = o_rx_valid;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            seen = seen | o_rx_valid;
        end
        chk("arst_no_rxv", seen, 0);
        slave_byte = 8'hA6;
        send(8'h5A, 8'h00, 1'b0, acc);
        recv(acc, 8'h5A, slave_byte);

        for (int i = 0; i < 3; i++) begin
            tx = (i == 0) ? 8'hC3 : 8'($urandom);
            w = 0;
            while (!rdy1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            tx_data1  = tx;
            tx_valid1 = 1'b1;
            @(negedge clk);
            acc = cyc;
            tx_valid1 = 1'b0;
            tx_data1  = 8'($urandom);
            w = 0;
            while (!rxv1 && w < 200) begin
                @(negedge clk);
                w++;
            end
            chk("div1_latency", cyc - acc, 18);
            chk("div1_loopback", rxd1, tx);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
